sdram_traffic_gen: RTL and testbench

//  Synthesizable, parametrised write-then-read traffic generator and checker for the SDRAM controller user interface.
//  It replaces hand-timed wr_trig/rd_trig pulses with a start-driven sequence.
//  The sequence writes NUM_BURSTS bursts of a selectable data pattern, reads them back, and compares every beat.
//  It sits between board/bench control and sdram_top's user port, and reports pass/fail, error count and first failing address.

---
 rtl/sdram_traffic_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_traffic_gen.sv
// Write-then-read traffic generator and checker for the SDRAM controller user port.
// Writes NUM_BURSTS bursts of a selectable pattern, reads them back and counts bad beats.
module sdram_traffic_gen #(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       BURST_LEN  = 4,
    parameter int unsigned       NUM_BURSTS = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_W-1:0] SEED       = DATA_W'(16'h5A5A),
    parameter int unsigned       TIMEOUT    = 4096
) (
    input  logic              S_CLK,
    input  logic              S_RSTn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              ctrl_ready,
    output logic              cmd_wr_trig,
    output logic              cmd_rd_trig,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              wr_data_req,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_data_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              cmd_done,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned BST_W  = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0] BEATS      = BEAT_W'(BURST_LEN);
    localparam logic [BST_W-1:0]  LAST_BURST = BST_W'(NUM_BURSTS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ISS  = 3'd1,
        WR_WAIT = 3'd2,
        RD_ISS  = 3'd3,
        RD_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t              state_q, state_n;
    logic [BST_W-1:0]    burst_q, burst_n;
    logic [BEAT_W-1:0]   beat_q, beat_n, beat_eff;
    logic [TMO_W-1:0]    tmo_q, tmo_n;
    logic [1:0]          mode_q, mode_n;
    logic                cmd_wr_trig_n, cmd_rd_trig_n, busy_n, pass_n, fail_n, timeout_n;
    logic [ADDR_W-1:0]   cmd_addr_n, first_err_addr_n, err_addr_c;
    logic [DATA_W-1:0]   wr_data_n;
    logic [15:0]         err_cnt_n;
    logic [31:0]         err_add, err_sum;
    logic                done_ok;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [BST_W-1:0] b);
        return ADDR_W'(32'(BASE_ADDR) + 32'(b) * BURST_LEN);
    endfunction

    // Data for beat 'beat' of burst 'b'; 'a' is that burst's start address
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [BST_W-1:0] b,
                                                  input logic [BEAT_W-1:0] beat,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] i;
        i = DATA_W'(32'(b) * BURST_LEN + 32'(beat));
        case (m)
            2'd0:    return i + SEED;
            2'd1:    return DATA_W'(1) << (i % DATA_W'(DATA_W));
            2'd2:    return ~(i + SEED);
            default: return DATA_W'(a + ADDR_W'(beat));
        endcase
    endfunction

    always_ff @(posedge S_CLK or negedge S_RSTn) begin
        if (!S_RSTn) begin
            state_q        <= IDLE;
            burst_q        <= '0;
            beat_q         <= '0;
            tmo_q          <= '0;
            mode_q         <= '0;
            cmd_wr_trig    <= 1'b0;
            cmd_rd_trig    <= 1'b0;
            cmd_addr       <= '0;
            wr_data        <= '0;
            busy           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            state_q        <= state_n;
            burst_q        <= burst_n;
            beat_q         <= beat_n;
            tmo_q          <= tmo_n;
            mode_q         <= mode_n;
            cmd_wr_trig    <= cmd_wr_trig_n;
            cmd_rd_trig    <= cmd_rd_trig_n;
            cmd_addr       <= cmd_addr_n;
            wr_data        <= wr_data_n;
            busy           <= busy_n;
            pass           <= pass_n;
            fail           <= fail_n;
            timeout        <= timeout_n;
            err_cnt        <= err_cnt_n;
            first_err_addr <= first_err_addr_n;
        end
    end

    always_comb begin
        state_n          = state_q;
        burst_n          = burst_q;
        beat_n           = beat_q;
        tmo_n            = tmo_q;
        mode_n           = mode_q;
        cmd_wr_trig_n    = 1'b0;
        cmd_rd_trig_n    = 1'b0;
        cmd_addr_n       = cmd_addr;
        wr_data_n        = wr_data;
        busy_n           = busy;
        pass_n           = pass;
        fail_n           = fail;
        timeout_n        = timeout;
        err_cnt_n        = err_cnt;
        first_err_addr_n = first_err_addr;
        err_add          = '0;
        err_addr_c       = cmd_addr;
        beat_eff         = beat_q;
        err_sum          = '0;
        // A burst's cmd_done cannot arrive in the cycle its trigger is presented
        done_ok          = cmd_done && !cmd_wr_trig && !cmd_rd_trig;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pass_n           = 1'b0;
                    fail_n           = 1'b0;
                    timeout_n        = 1'b0;
                    err_cnt_n        = '0;
                    first_err_addr_n = '0;
                    busy_n           = 1'b1;
                    mode_n           = mode;
                    burst_n          = '0;
                    state_n          = WR_ISS;
                end
            end
            WR_ISS: begin
                if (ctrl_ready) begin
                    cmd_wr_trig_n = 1'b1;
                    cmd_addr_n    = burst_addr(burst_q);
                    wr_data_n     = pattern(mode_q, burst_q, '0, burst_addr(burst_q));
                    beat_n        = '0;
                    tmo_n         = '0;
                    state_n       = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wr_data_req) begin
                    if (beat_q < BEATS) begin
                        beat_n = beat_q + BEAT_W'(1);
                        if (beat_q + BEAT_W'(1) < BEATS)
                            wr_data_n = pattern(mode_q, burst_q, beat_q + BEAT_W'(1), cmd_addr);
                    end else begin
                        err_add    = 32'd1;
                        err_addr_c = cmd_addr + ADDR_W'(beat_q);
                    end
                end
                if (done_ok) begin
                    if (burst_q == LAST_BURST) begin
                        burst_n = '0;
                        state_n = RD_ISS;
                    end else begin
                        burst_n = burst_q + BST_W'(1);
                        state_n = WR_ISS;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = FIN;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            RD_ISS: begin
                if (ctrl_ready) begin
                    cmd_rd_trig_n = 1'b1;
                    cmd_addr_n    = burst_addr(burst_q);
                    beat_n        = '0;
                    tmo_n         = '0;
                    state_n       = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_data_vld) begin
                    if (beat_q < BEATS) begin
                        beat_eff = beat_q + BEAT_W'(1);
                        if (rd_data != pattern(mode_q, burst_q, beat_q, cmd_addr)) begin
                            err_add    = 32'd1;
                            err_addr_c = cmd_addr + ADDR_W'(beat_q);
                        end
                    end else begin
                        err_add    = 32'd1;
                        err_addr_c = cmd_addr + ADDR_W'(beat_q);
                    end
                    beat_n = beat_eff;
                end
                if (done_ok) begin
                    // Every beat never delivered by cmd_done counts as one error
                    if (beat_eff < BEATS) begin
                        if (err_add == '0)
                            err_addr_c = cmd_addr + ADDR_W'(beat_eff);
                        err_add = err_add + 32'(BEATS - beat_eff);
                    end
                    if (burst_q == LAST_BURST) begin
                        burst_n = '0;
                        state_n = FIN;
                    end else begin
                        burst_n = burst_q + BST_W'(1);
                        state_n = RD_ISS;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = FIN;
                end else begin
                    tmo_n = tmo_q + TMO_W'(1);
                end
            end
            FIN: begin
                pass_n  = (err_cnt == '0) && !timeout;
                fail_n  = !((err_cnt == '0) && !timeout);
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Saturating error accumulation; first error address latched once per run
        err_sum = 32'(err_cnt) + err_add;
        if (err_add != '0) begin
            if (err_cnt == '0)
                first_err_addr_n = err_addr_c;
            err_cnt_n = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : 16'(err_sum);
        end
    end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: three configurations driven by an ideal-memory controller model
// with fault injection; trigger addresses and write beats are checked against a scoreboard.
module tb_sdram_traffic_gen;

    localparam int NI  = 3;
    localparam int TMO = 4096;

    logic clk = 1'b0;
    logic rst_n;

    logic        start       [NI];
    logic [1:0]  mode        [NI];
    logic        ctrl_ready  [NI];
    logic        wr_data_req [NI];
    logic        rd_data_vld [NI];
    logic [15:0] rd_data     [NI];
    logic        cmd_done    [NI];
    logic        cmd_wr_trig [NI];
    logic        cmd_rd_trig [NI];
    logic [11:0] cmd_addr    [NI];
    logic [15:0] wr_data     [NI];
    logic        busy        [NI];
    logic        pass        [NI];
    logic        fail        [NI];
    logic        timeout     [NI];
    logic [15:0] err_cnt     [NI];
    logic [11:0] first_err_addr [NI];

    int bl_c   [NI] = '{4, 8, 4};
    int nb_c   [NI] = '{8, 4, 2};
    int base_c [NI] = '{0, 0, 'hFFC};

    int errors = 0;
    int checks = 0;
    int tmo_cycles;

    logic [15:0] mem [int];
    bit          exp_rd_q   [$];
    logic [11:0] exp_addr_q [$];
    logic [15:0] exp_wd_q   [$];
    logic [11:0] obs_addr   [$];

    always #5 clk = ~clk;

    sdram_traffic_gen u_dut0 (
        .S_CLK(clk), .S_RSTn(rst_n), .start(start[0]), .mode(mode[0]), .ctrl_ready(ctrl_ready[0]),
        .cmd_wr_trig(cmd_wr_trig[0]), .cmd_rd_trig(cmd_rd_trig[0]), .cmd_addr(cmd_addr[0]),
        .wr_data_req(wr_data_req[0]), .wr_data(wr_data[0]), .rd_data_vld(rd_data_vld[0]),
        .rd_data(rd_data[0]), .cmd_done(cmd_done[0]), .busy(busy[0]), .pass(pass[0]),
        .fail(fail[0]), .timeout(timeout[0]), .err_cnt(err_cnt[0]), .first_err_addr(first_err_addr[0])
    );

    sdram_traffic_gen #(.BURST_LEN(8), .NUM_BURSTS(4)) u_dut1 (
        .S_CLK(clk), .S_RSTn(rst_n), .start(start[1]), .mode(mode[1]), .ctrl_ready(ctrl_ready[1]),
        .cmd_wr_trig(cmd_wr_trig[1]), .cmd_rd_trig(cmd_rd_trig[1]), .cmd_addr(cmd_addr[1]),
        .wr_data_req(wr_data_req[1]), .wr_data(wr_data[1]), .rd_data_vld(rd_data_vld[1]),
        .rd_data(rd_data[1]), .cmd_done(cmd_done[1]), .busy(busy[1]), .pass(pass[1]),
        .fail(fail[1]), .timeout(timeout[1]), .err_cnt(err_cnt[1]), .first_err_addr(first_err_addr[1])
    );

    sdram_traffic_gen #(.NUM_BURSTS(2), .BASE_ADDR(12'hFFC)) u_dut2 (
        .S_CLK(clk), .S_RSTn(rst_n), .start(start[2]), .mode(mode[2]), .ctrl_ready(ctrl_ready[2]),
        .cmd_wr_trig(cmd_wr_trig[2]), .cmd_rd_trig(cmd_rd_trig[2]), .cmd_addr(cmd_addr[2]),
        .wr_data_req(wr_data_req[2]), .wr_data(wr_data[2]), .rd_data_vld(rd_data_vld[2]),
        .rd_data(rd_data[2]), .cmd_done(cmd_done[2]), .busy(busy[2]), .pass(pass[2]),
        .fail(fail[2]), .timeout(timeout[2]), .err_cnt(err_cnt[2]), .first_err_addr(first_err_addr[2])
    );

    function automatic logic [15:0] exp_pat(input logic [1:0] m, input int i, input logic [11:0] a);
        logic [15:0] iw;
        iw = 16'(i);
        case (m)
            2'd0:    return iw + 16'h5A5A;
            2'd1:    return 16'h0001 << (i % 16);
            2'd2:    return ~(iw + 16'h5A5A);
            default: return 16'(a);
        endcase
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; mode[i] = 2'd0; ctrl_ready[i] = 1'b0; wr_data_req[i] = 1'b0;
            rd_data_vld[i] = 1'b0; rd_data[i] = 16'h0000; cmd_done[i] = 1'b0;
        end
    endtask

    // Ideal controller + memory for one full run with optional faults
    task automatic run(input int sel, input logic [1:0] m, input int rdy_delay, input int corrupt_addr,
                       input int extra_burst, input int withhold_k, input bit mid_start);
        int cyc, nbeats, ntrig;
        bit exp_rd;
        logic [11:0] a, ab, ba;
        logic [15:0] d;
        exp_rd_q.delete(); exp_addr_q.delete(); exp_wd_q.delete(); obs_addr.delete(); mem.delete();
        tmo_cycles = -1;
        for (int ph = 0; ph < 2; ph++)
            for (int k = 0; k < nb_c[sel]; k++) begin
                ba = 12'(base_c[sel] + k * bl_c[sel]);
                exp_rd_q.push_back(ph == 1);
                exp_addr_q.push_back(ba);
                if (ph == 0)
                    for (int b = 0; b < bl_c[sel]; b++)
                        exp_wd_q.push_back(exp_pat(m, k * bl_c[sel] + b, ba + 12'(b)));
            end
        ctrl_ready[sel] = (rdy_delay == 0);
        mode[sel] = m;
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        checks++;
        if (busy[sel] !== 1'b1) begin
            errors++; $display("FAIL busy_after_start: got %b, want 1", busy[sel]);
        end
        ntrig = 0;
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            if (cmd_wr_trig[sel] || cmd_rd_trig[sel]) ntrig++;
        end
        if (rdy_delay > 0) begin
            checks++;
            if (ntrig !== 0) begin
                errors++; $display("FAIL trig_while_not_ready: got %0d pulses, want 0", ntrig);
            end
            ctrl_ready[sel] = 1'b1;
        end
        for (int ph = 0; ph < 2; ph++)
            for (int k = 0; k < nb_c[sel]; k++) begin
                cyc = 0;
                while (!cmd_wr_trig[sel] && !cmd_rd_trig[sel] && cyc < 300) begin
                    @(negedge clk); cyc++;
                end
                checks++;
                if (cyc >= 300) begin
                    errors++; $display("FAIL trig_wait: none after %0d cycles, want phase %0d burst %0d", cyc, ph, k);
                    return;
                end
                exp_rd = exp_rd_q.pop_front();
                a = exp_addr_q.pop_front();
                checks++;
                if ({cmd_wr_trig[sel], cmd_rd_trig[sel]} !== (exp_rd ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL trig_kind: got wr/rd=%b%b, want rd=%b (burst %0d)",
                                       cmd_wr_trig[sel], cmd_rd_trig[sel], exp_rd, k);
                end
                checks++;
                if (cmd_addr[sel] !== a) begin
                    errors++; $display("FAIL cmd_addr: got %h, want %h", cmd_addr[sel], a);
                end
                obs_addr.push_back(cmd_addr[sel]);
                if (ph == 0 && k == withhold_k) begin
                    cyc = 0;
                    while (busy[sel] && cyc < TMO + 50) begin
                        @(negedge clk); cyc++;
                    end
                    tmo_cycles = cyc;
                    return;
                end
                if (mid_start && ph == 0 && k == nb_c[sel] / 2) begin
                    start[sel] = 1'b1; mode[sel] = ~m;
                end
                @(negedge clk);
                start[sel] = 1'b0; mode[sel] = m;
                checks++;
                if (cmd_wr_trig[sel] || cmd_rd_trig[sel]) begin
                    errors++; $display("FAIL trig_width: trigger still high one cycle later, want 0");
                end
                nbeats = bl_c[sel] + ((ph == 1 && k == extra_burst) ? 1 : 0);
                for (int b = 0; b < nbeats; b++) begin
                    ab = a + 12'(b);
                    if (ph == 0) begin
                        wr_data_req[sel] = 1'b1;
                        d = exp_wd_q.pop_front();
                        checks++;
                        if (wr_data[sel] !== d) begin
                            errors++; $display("FAIL wr_data@%h: got %h, want %h", ab, wr_data[sel], d);
                        end
                        mem[int'(ab)] = wr_data[sel];
                    end else begin
                        rd_data_vld[sel] = 1'b1;
                        rd_data[sel] = mem[int'(ab)] ^ ((int'(ab) == corrupt_addr) ? 16'h0001 : 16'h0000);
                    end
                    @(negedge clk);
                end
                wr_data_req[sel] = 1'b0; rd_data_vld[sel] = 1'b0; rd_data[sel] = 16'h0000;
                cmd_done[sel] = 1'b1;
                @(negedge clk);
                cmd_done[sel] = 1'b0;
            end
        cyc = 0;
        while (busy[sel] && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (busy[sel] !== 1'b0) begin
            errors++; $display("FAIL run_end: busy got %b, want 0", busy[sel]);
        end
    endtask

    task automatic test_reset();
        int cyc;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_wr_trig[0], cmd_rd_trig[0], busy[0], pass[0], fail[0], timeout[0]} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b%b%b%b%b%b, want 000000", cmd_wr_trig[0],
                               cmd_rd_trig[0], busy[0], pass[0], fail[0], timeout[0]);
        end
        checks++;
        if ({cmd_addr[0], wr_data[0], err_cnt[0], first_err_addr[0]} !== 56'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h, want all 0", cmd_addr[0], wr_data[0],
                               err_cnt[0], first_err_addr[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        ctrl_ready[0] = 1'b1; mode[0] = 2'd0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (!cmd_wr_trig[0] && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        // One beat too many: the last beat must be held and an error logged at addr 4
        for (int b = 0; b < 5; b++) begin
            wr_data_req[0] = 1'b1;
            @(negedge clk);
        end
        wr_data_req[0] = 1'b0;
        checks++;
        if (wr_data[0] !== 16'h5A5D) begin
            errors++; $display("FAIL wr_overrun_hold: got %h, want 5a5d", wr_data[0]);
        end
        checks++;
        if (err_cnt[0] !== 16'd1 || first_err_addr[0] !== 12'h004) begin
            errors++; $display("FAIL wr_overrun_err: got cnt=%0d addr=%h, want cnt=1 addr=004",
                               err_cnt[0], first_err_addr[0]);
        end
        cmd_done[0] = 1'b1;
        @(negedge clk);
        cmd_done[0] = 1'b0;
        cyc = 0;
        while (!cmd_wr_trig[0] && cyc < 20) begin @(negedge clk); cyc++; end
        checks++;
        if (busy[0] !== 1'b1 || cmd_addr[0] !== 12'h004) begin
            errors++; $display("FAIL pre_reset: got busy=%b addr=%h, want busy=1 addr=004", busy[0], cmd_addr[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_wr_trig[0], busy[0], pass[0], fail[0], timeout[0]} !== 5'b0 ||
            {cmd_addr[0], wr_data[0], err_cnt[0], first_err_addr[0]} !== 56'h0) begin
            errors++; $display("FAIL midrun_reset: got busy=%b addr=%h wd=%h err=%0d fea=%h, want all 0",
                               busy[0], cmd_addr[0], wr_data[0], err_cnt[0], first_err_addr[0]);
        end
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        run(0, 2'd0, 0, -1, -1, -1, 1'b0);
        checks++;
        if (pass[0] !== 1'b1 || fail[0] !== 1'b0 || timeout[0] !== 1'b0) begin
            errors++; $display("FAIL clean_result: got pass=%b fail=%b to=%b, want 1 0 0", pass[0], fail[0], timeout[0]);
        end
        checks++;
        if (err_cnt[0] !== 16'd0 || first_err_addr[0] !== 12'h000) begin
            errors++; $display("FAIL clean_err: got %0d @%h, want 0 @000", err_cnt[0], first_err_addr[0]);
        end
        checks++;
        if (obs_addr.size() !== 16) begin
            errors++; $display("FAIL clean_trig_count: got %0d, want 16", obs_addr.size());
        end
    endtask

    task automatic test_walking_one();
        run(1, 2'd1, 0, -1, -1, -1, 1'b0);
        checks++;
        if (!mem.exists(17) || mem[17] !== 16'h0002) begin
            errors++; $display("FAIL walk_beat17: got %h, want 0002", mem.exists(17) ? mem[17] : 16'hxxxx);
        end
        checks++;
        if (pass[1] !== 1'b1 || err_cnt[1] !== 16'd0) begin
            errors++; $display("FAIL walk_result: got pass=%b err=%0d, want pass=1 err=0", pass[1], err_cnt[1]);
        end
    endtask

    task automatic test_corrupt();
        run(0, 2'd0, 0, 9, -1, -1, 1'b0);
        checks++;
        if (fail[0] !== 1'b1 || pass[0] !== 1'b0) begin
            errors++; $display("FAIL corrupt_flags: got pass=%b fail=%b, want 0 1", pass[0], fail[0]);
        end
        checks++;
        if (err_cnt[0] !== 16'd1 || first_err_addr[0] !== 12'h009) begin
            errors++; $display("FAIL corrupt_err: got %0d @%h, want 1 @009", err_cnt[0], first_err_addr[0]);
        end
    endtask

    task automatic test_timeout();
        run(0, 2'd0, 0, -1, -1, 2, 1'b0);
        checks++;
        if (tmo_cycles < TMO || tmo_cycles > TMO + 3) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles, want %0d..%0d", tmo_cycles, TMO, TMO + 3);
        end
        checks++;
        if (timeout[0] !== 1'b1 || fail[0] !== 1'b1 || pass[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL timeout_flags: got to=%b fail=%b pass=%b busy=%b, want 1 1 0 0",
                               timeout[0], fail[0], pass[0], busy[0]);
        end
    endtask

    task automatic test_ready_extra_midstart();
        run(0, 2'd2, 100, -1, 0, -1, 1'b1);
        checks++;
        if (err_cnt[0] !== 16'd1 || first_err_addr[0] !== 12'h004) begin
            errors++; $display("FAIL extra_beat_err: got %0d @%h, want 1 @004", err_cnt[0], first_err_addr[0]);
        end
        checks++;
        if (fail[0] !== 1'b1 || pass[0] !== 1'b0 || timeout[0] !== 1'b0) begin
            errors++; $display("FAIL extra_beat_flags: got pass=%b fail=%b to=%b, want 0 1 0", pass[0], fail[0], timeout[0]);
        end
    endtask

    task automatic test_addr_wrap();
        run(2, 2'd3, 0, -1, -1, -1, 1'b0);
        checks++;
        if (obs_addr.size() < 2 || obs_addr[0] !== 12'hFFC) begin
            errors++; $display("FAIL wrap_addr0: got %h, want ffc", (obs_addr.size() > 0) ? obs_addr[0] : 12'hxxx);
        end
        checks++;
        if (obs_addr.size() < 2 || obs_addr[1] !== 12'h000) begin
            errors++; $display("FAIL wrap_addr1: got %h, want 000", (obs_addr.size() > 1) ? obs_addr[1] : 12'hxxx);
        end
        checks++;
        if (pass[2] !== 1'b1 || err_cnt[2] !== 16'd0) begin
            errors++; $display("FAIL wrap_result: got pass=%b err=%0d, want 1 0", pass[2], err_cnt[2]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_clean();
        test_walking_one();
        test_corrupt();
        test_timeout();
        test_ready_extra_midstart();
        test_addr_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
